// File: rtl/reset_sequencer.sv
// Board-level reset sequencer: synchronises the reset pin and clock-ready flags, then
// releases NUM_DOMAINS resets in index order. Define RSTSEQ_CAUSE_EN to add cause_o.
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int NUM_READY      = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic                   clk_sys_i,
  input  logic                   reset_async_i,
  input  logic [NUM_READY-1:0]   ready_async_i,
  input  logic                   sw_reset_i,
  output logic [NUM_DOMAINS-1:0] reset_o,
  output logic                   done_o
`ifdef RSTSEQ_CAUSE_EN
  ,
  output logic [1:0]             cause_o
`endif
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

  if (NUM_DOMAINS < 1) begin : g_bad_domains
    $error("reset_sequencer: NUM_DOMAINS must be >= 1");
  end
  if (NUM_READY < 1) begin : g_bad_ready
    $error("reset_sequencer: NUM_READY must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (STAGGER_CYCLES < 1) begin : g_bad_stagger
    $error("reset_sequencer: STAGGER_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_READY,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] rdy_sync;
  logic                   rst_ok;
  logic                   ready_s;

  state_t                 state;
  logic [CNT_W-1:0]       count;
  logic [IDX_W-1:0]       idx;

  // Both chains clear on the pin so the FSM cannot act on stale ready history.
  always_ff @(posedge clk_sys_i or negedge reset_async_i) begin
    if (!reset_async_i) begin
      rst_sync <= '0;
      rdy_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
      rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], &ready_async_i};
    end
  end

  assign rst_ok  = rst_sync[SYNC_STAGES-1];
  assign ready_s = rdy_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_sys_i or negedge reset_async_i) begin
    if (!reset_async_i) begin
      state   <= ST_RESET;
      count   <= '0;
      idx     <= '0;
      reset_o <= '1;
      done_o  <= 1'b0;
`ifdef RSTSEQ_CAUSE_EN
      cause_o <= 2'd0;
`endif
    end else begin
      case (state)
        ST_RESET: begin
          if (rst_ok) state <= ST_WAIT_READY;
        end

        ST_WAIT_READY: begin
          if (ready_s) begin
            state <= ST_HOLD;
            count <= HOLD_LOAD;
          end
        end

        ST_HOLD, ST_RELEASE, ST_RUN: begin
          // Ready loss is checked first so it wins over a simultaneous software request.
          if (!ready_s) begin
            state   <= ST_WAIT_READY;
            reset_o <= '1;
            done_o  <= 1'b0;
`ifdef RSTSEQ_CAUSE_EN
            cause_o <= 2'd1;
`endif
          end else if (sw_reset_i) begin
            state   <= ST_HOLD;
            count   <= HOLD_LOAD;
            reset_o <= '1;
            done_o  <= 1'b0;
`ifdef RSTSEQ_CAUSE_EN
            cause_o <= 2'd2;
`endif
          end else if (state == ST_HOLD) begin
            if (count == '0) begin
              reset_o[0] <= 1'b0;
              if (NUM_DOMAINS == 1) begin
                state  <= ST_RUN;
                done_o <= 1'b1;
              end else begin
                state <= ST_RELEASE;
                idx   <= IDX_W'(1);
                count <= STAGGER_LOAD;
              end
            end else begin
              count <= count - 1'b1;
            end
          end else if (state == ST_RELEASE) begin
            if (count == '0) begin
              reset_o[idx] <= 1'b0;
              if (idx == LAST_IDX) begin
                state  <= ST_RUN;
                done_o <= 1'b1;
              end else begin
                idx   <= idx + 1'b1;
                count <= STAGGER_LOAD;
              end
            end else begin
              count <= count - 1'b1;
            end
          end
        end

        default: begin
          state   <= ST_RESET;
          reset_o <= '1;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer at default parameters.
// Checks cause_o as well when built with RSTSEQ_CAUSE_EN.
module tb_reset_sequencer;

  logic       clk_sys_i;
  logic       reset_async_i;
  logic [1:0] ready_async_i;
  logic       sw_reset_i;
  logic [3:0] reset_o;
  logic       done_o;
`ifdef RSTSEQ_CAUSE_EN
  logic [1:0] cause_o;
`endif

  int check_count = 0;
  int error_count = 0;
  int edge_cnt    = 0;

  reset_sequencer dut (
    .clk_sys_i     (clk_sys_i),
    .reset_async_i (reset_async_i),
    .ready_async_i (ready_async_i),
    .sw_reset_i    (sw_reset_i),
    .reset_o       (reset_o),
    .done_o        (done_o)
`ifdef RSTSEQ_CAUSE_EN
    ,
    .cause_o       (cause_o)
`endif
  );

  initial clk_sys_i = 1'b0;
  always #5 clk_sys_i = ~clk_sys_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edge_cnt, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ready, input logic sw);
    ready_async_i = ready;
    sw_reset_i    = sw;
  endtask

  // Advances to the given edge number, leaving time 1ns after that edge.
  task automatic stepTo(input int target);
    while (edge_cnt < target) begin
      @(posedge clk_sys_i);
      #1;
      edge_cnt++;
    end
  endtask

  task automatic checkState(input string tag, input logic [3:0] exp_rst, input logic exp_done);
    checkOutput({tag, ".reset_o"}, 32'(reset_o), 32'(exp_rst));
    checkOutput({tag, ".done_o"}, 32'(done_o), 32'(exp_done));
  endtask

  task automatic checkCause(input string tag, input logic [1:0] exp);
`ifdef RSTSEQ_CAUSE_EN
    checkOutput({tag, ".cause_o"}, 32'(cause_o), 32'(exp));
`else
    if (exp > 2'd3) $display("[TB] unreachable %s", tag);
`endif
  endtask

  // Pulses the pin low for 3ns between edges; next rising edge becomes edge 1.
  task automatic pulsePin(input string tag);
    #2;
    reset_async_i = 1'b0;
    #1;
    checkState({tag, ".async"}, 4'b1111, 1'b0);
    checkCause({tag, ".async"}, 2'd0);
    #2;
    reset_async_i = 1'b1;
    edge_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_async_i = 1'b0;
    applyStimulus(2'b11, 1'b0);

    // Power-up with ready already high.
    repeat (3) @(posedge clk_sys_i);
    #1;
    checkState("por_held", 4'b1111, 1'b0);
    checkCause("por_held", 2'd0);
    #2;
    reset_async_i = 1'b1;
    edge_cnt = 0;
    stepTo(19); checkState("por_e19", 4'b1111, 1'b0);
    stepTo(20); checkState("por_e20", 4'b1110, 1'b0);
    stepTo(27); checkState("por_e27", 4'b1110, 1'b0);
    stepTo(28); checkState("por_e28", 4'b1100, 1'b0);
    stepTo(35); checkState("por_e35", 4'b1100, 1'b0);
    stepTo(36); checkState("por_e36", 4'b1000, 1'b0);
    stepTo(43); checkState("por_e43", 4'b1000, 1'b0);
    stepTo(44); checkState("por_e44", 4'b0000, 1'b1);

    // Fresh sequence, then software reset sampled at edge 31.
    pulsePin("sw_pin");
    stepTo(30); checkState("sw_e30", 4'b1100, 1'b0);
    applyStimulus(2'b11, 1'b1);
    stepTo(31); checkState("sw_e31", 4'b1111, 1'b0);
    checkCause("sw_e31", 2'd2);
    applyStimulus(2'b11, 1'b0);
    stepTo(46); checkState("sw_e46", 4'b1111, 1'b0);
    stepTo(47); checkState("sw_e47", 4'b1110, 1'b0);
    stepTo(70); checkState("sw_e70", 4'b1000, 1'b0);
    stepTo(71); checkState("sw_e71", 4'b0000, 1'b1);

    // One-cycle drop of ready[1] while running.
    stepTo(80);
    applyStimulus(2'b01, 1'b0);
    stepTo(81);
    applyStimulus(2'b11, 1'b0);
    stepTo(82); checkState("rdy_e82", 4'b0000, 1'b1);
    stepTo(83); checkState("rdy_e83", 4'b1111, 1'b0);
    checkCause("rdy_e83", 2'd1);
    stepTo(99);  checkState("rdy_e99", 4'b1111, 1'b0);
    stepTo(100); checkState("rdy_e100", 4'b1110, 1'b0);
    stepTo(123); checkState("rdy_e123", 4'b1000, 1'b0);
    stepTo(124); checkState("rdy_e124", 4'b0000, 1'b1);

    // Ready loss and software request seen on the same edge: ready loss wins.
    stepTo(130);
    applyStimulus(2'b10, 1'b0);
    stepTo(131);
    applyStimulus(2'b11, 1'b0);
    stepTo(132);
    applyStimulus(2'b11, 1'b1);
    stepTo(133); checkState("both_e133", 4'b1111, 1'b0);
    checkCause("both_e133", 2'd1);
    applyStimulus(2'b11, 1'b0);
    stepTo(149); checkState("both_e149", 4'b1111, 1'b0);
    stepTo(150); checkState("both_e150", 4'b1110, 1'b0);

    // Ready low for 100 cycles after pin release.
    stepTo(160);
    applyStimulus(2'b00, 1'b0);
    pulsePin("nrdy_pin");
    stepTo(50);  checkState("nrdy_e50", 4'b1111, 1'b0);
    stepTo(100); checkState("nrdy_e100", 4'b1111, 1'b0);
    applyStimulus(2'b11, 1'b0);
    stepTo(118); checkState("nrdy_e118", 4'b1111, 1'b0);
    stepTo(119); checkState("nrdy_e119", 4'b1110, 1'b0);

    // Pin pulse mid-release restarts from edge 1; sw request ignored while waiting.
    stepTo(125); checkState("pin_e125", 4'b1110, 1'b0);
    pulsePin("pin_mid");
    stepTo(2);
    applyStimulus(2'b11, 1'b1);
    stepTo(3);
    applyStimulus(2'b11, 1'b0);
    stepTo(19); checkState("pin_e19", 4'b1111, 1'b0);
    checkCause("pin_e19", 2'd0);
    stepTo(20); checkState("pin_e20", 4'b1110, 1'b0);
    stepTo(43); checkState("pin_e43", 4'b1000, 1'b0);
    stepTo(44); checkState("pin_e44", 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
